fl_div_32bit: RTL
=================

FL_DIV_32BIT -- requirements
Module: fl_div_32bit

Interface
REQ-001 SHALL have parameter EXP_BIAS, default 127, IEEE-754 single-precision exponent bias.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; operands sampled at the rising edge where start=1 in IDLE.
REQ-005 SHALL have port in0  input  32  dividend, IEEE-754 single.
REQ-006 SHALL have port in1  input  32  divisor, IEEE-754 single.
REQ-007 SHALL have port quotient  output  32  registered result, held until the next result is written.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; quotient valid in the same cycle.

Function
REQ-010 SHALL implement states IDLE, DIVIDE, NORM; IDLE->DIVIDE on start with normal operands, DIVIDE->NORM after the last iteration, NORM->IDLE unconditionally.
REQ-011 SHALL, on start with a special operand, stay in IDLE, write quotient and pulse done one cycle after the sampling edge.
REQ-012 SHALL use these special-case priorities: in0[30:0]==0 or in0[30:23]==8'hFF -> quotient={sign,in0[30:0]}; else in1[30:0]==0 -> {sign,8'hFF,23'd0}; else in1[30:23]==8'hFF -> {sign,31'd0}.
REQ-013 SHALL compute sign = in0[31] XOR in1[31] for all results.
REQ-014 SHALL treat exponent field 0 with nonzero mantissa as normal with implicit 1 (no denormal support).
REQ-015 SHALL perform restoring division of {1,in0[22:0]} by {1,in1[22:0]}, one quotient bit per cycle, 25 iterations, using a 25-bit remainder.
REQ-016 SHALL form quotient bits q[24:0]; if q[24]=1 mantissa=q[23:1] and e=e0-e1+EXP_BIAS, else mantissa=q[22:0] and e=e0-e1+EXP_BIAS-1.
REQ-017 SHALL evaluate e as a signed 10-bit value; e>=255 -> {sign,8'hFF,23'd0}; e<=0 -> {sign,31'd0}.
REQ-018 SHALL give normal-operand latency of 26 cycles: done high in the cycle after edge N+26, where edge N sampled start.
REQ-019 SHALL ignore start while busy=1; operands captured internally, so in0/in1 may change after the sampling edge.
REQ-020 SHALL accept a new start in the cycle done is high, since state is IDLE then.

Reset
REQ-021 SHALL, on rst_n=0, immediately force state=IDLE, busy=0, done=0, quotient=32'd0, and clear remainder/counter.
REQ-022 SHALL abandon an in-flight division on reset with no done pulse; the first start after rst_n rises is processed normally.

Configuration
REQ-023 SHALL, with FL_DIV_ROUND_EN defined, run 26 iterations plus a sticky bit (remainder!=0) and round to nearest even; mantissa carry-out increments e before the REQ-017 checks; normal latency becomes 27 cycles.
REQ-024 SHALL, without FL_DIV_ROUND_EN, truncate as in REQ-016 with 26-cycle latency.

Structure
REQ-025 SHALL place EXP_BIAS default, FL_EXP_MAX (8'hFF), field widths and the state enumeration in shared package fl_pkg.
REQ-026 SHALL implement special-case classification and the REQ-012 result in combinational sub-module fl_div_special.

Verification
REQ-027 SHALL check 0x40C00000 / 0x40000000 (6.0/2.0) -> quotient 0x40400000, done 26 cycles after start (27 with FL_DIV_ROUND_EN).
REQ-028 SHALL check 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA truncated; 0x3EAAAAAB with FL_DIV_ROUND_EN.
REQ-029 SHALL check 0xBF800000 / 0x00000000 -> 0xFF800000 and 0x00000000 / 0x40000000 -> 0x00000000, each with done one cycle after start.
REQ-030 SHALL check 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow) and 0x00800000 / 0x7E800000 -> 0x00000000 (underflow).
REQ-031 SHALL check rst_n pulsed low 10 cycles into a division -> busy=0, done=0, quotient=0 immediately; a following 6.0/2.0 returns 0x40400000.
REQ-032 SHALL check start pulsed with new operands at cycle 5 of a busy division -> ignored; the first result is unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/fl_pkg.sv
// Shared constants, field widths and FSM state encoding for the single-precision divider.
package fl_pkg;

  localparam int unsigned FL_W        = 32;
  localparam int unsigned FL_EXP_W    = 8;
  localparam int unsigned FL_MAN_W    = 23;
  localparam int unsigned FL_E_W      = 10;
  localparam int unsigned FL_EXP_BIAS = 127;
  localparam logic [FL_EXP_W-1:0] FL_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2
  } fl_state_t;

endpackage

// File: rtl/fl_div_special.sv
// Combinational classification of zero/inf/NaN operands and the matching early quotient.
module fl_div_special
  import fl_pkg::*;
(
  input  logic [FL_W-1:0] in0,
  input  logic [FL_W-1:0] in1,
  output logic            special_c,
  output logic [FL_W-1:0] result_c
);

  logic sign;
  logic a_zero, a_max, b_zero, b_max;

  always_comb begin
    sign      = in0[FL_W-1] ^ in1[FL_W-1];
    a_zero    = (in0[FL_W-2:0] == '0);
    a_max     = (in0[FL_W-2:FL_MAN_W] == FL_EXP_MAX);
    b_zero    = (in1[FL_W-2:0] == '0);
    b_max     = (in1[FL_W-2:FL_MAN_W] == FL_EXP_MAX);
    special_c = 1'b0;
    result_c  = '0;
    // Dividend zero/inf/NaN passes through ahead of any divisor condition.
    if (a_zero || a_max) begin
      special_c = 1'b1;
      result_c  = {sign, in0[FL_W-2:0]};
    end else if (b_zero) begin
      special_c = 1'b1;
      result_c  = {sign, FL_EXP_MAX, FL_MAN_W'(0)};
    end else if (b_max) begin
      special_c = 1'b1;
      result_c  = {sign, (FL_W-1)'(0)};
    end
  end

endmodule

// File: rtl/fl_div_32bit.sv
// Sequential restoring IEEE-754 single divider, one quotient bit per cycle.
// Define FL_DIV_ROUND_EN for an extra iteration plus sticky bit and round-to-nearest-even.
module fl_div_32bit
  import fl_pkg::*;
#(
  parameter int unsigned EXP_BIAS = FL_EXP_BIAS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [FL_W-1:0] in0,
  input  logic [FL_W-1:0] in1,
  output logic [FL_W-1:0] quotient,
  output logic            busy,
  output logic            done
);

`ifdef FL_DIV_ROUND_EN
  localparam int unsigned ITER = 26;
`else
  localparam int unsigned ITER = 25;
`endif
  localparam int unsigned REM_W = 25;
  localparam int unsigned DIV_W = FL_MAN_W + 1;
  localparam int unsigned CNT_W = 5;

  fl_state_t state, state_nxt;

  logic [REM_W-1:0]        rem, rem_sel, rem_nxt;
  logic [REM_W:0]          diff;
  logic [DIV_W-1:0]        divisor;
  logic [ITER-1:0]         q;
  logic [CNT_W-1:0]        cnt;
  logic signed [FL_E_W-1:0] e_base, e_adj;
  logic                    sign, qbit, last_c;
  logic                    spec_c;
  logic [FL_W-1:0]         spec_res_c, norm_res_c, quotient_nxt;
  logic                    done_nxt;
  logic [FL_MAN_W-1:0]     mant;
`ifdef FL_DIV_ROUND_EN
  logic [DIV_W-1:0]        mant_rnd;
  logic                    guard, sticky;
`endif

  fl_div_special u_special (
    .in0       (in0),
    .in1       (in1),
    .special_c (spec_c),
    .result_c  (spec_res_c)
  );

  // One restoring step: subtract when the partial remainder covers the divisor.
  always_comb begin
    diff    = {1'b0, rem} - {2'b00, divisor};
    qbit    = ~diff[REM_W];
    rem_sel = qbit ? diff[REM_W-1:0] : rem;
    rem_nxt = rem_sel << 1;
    last_c  = (cnt == CNT_W'(ITER - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      divisor <= '0;
      q       <= '0;
      cnt     <= '0;
      e_base  <= '0;
      sign    <= 1'b0;
    end else if (state == IDLE) begin
      if (start && !spec_c) begin
        rem     <= {2'b01, in0[FL_MAN_W-1:0]};
        divisor <= {1'b1, in1[FL_MAN_W-1:0]};
        q       <= '0;
        cnt     <= '0;
        e_base  <= FL_E_W'(in0[FL_W-2:FL_MAN_W]) - FL_E_W'(in1[FL_W-2:FL_MAN_W])
                   + FL_E_W'(EXP_BIAS);
        sign    <= in0[FL_W-1] ^ in1[FL_W-1];
      end
    end else if (state == DIVIDE) begin
      rem <= rem_nxt;
      q   <= {q[ITER-2:0], qbit};
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Normalise the quotient bits, optionally round, then saturate the exponent.
  always_comb begin
    e_adj = e_base;
`ifdef FL_DIV_ROUND_EN
    if (q[ITER-1]) begin
      mant   = q[ITER-2:2];
      guard  = q[1];
      sticky = q[0] | (|rem);
    end else begin
      mant   = q[ITER-3:1];
      guard  = q[0];
      sticky = |rem;
      e_adj  = e_base - FL_E_W'(1);
    end
    mant_rnd = {1'b0, mant} + DIV_W'(guard & (sticky | mant[0]));
    mant     = mant_rnd[FL_MAN_W-1:0];
    if (mant_rnd[FL_MAN_W]) e_adj = e_adj + FL_E_W'(1);
`else
    if (q[ITER-1]) begin
      mant = q[ITER-2:1];
    end else begin
      mant  = q[ITER-3:0];
      e_adj = e_base - FL_E_W'(1);
    end
`endif
    if (e_adj >= 10'sd255)    norm_res_c = {sign, FL_EXP_MAX, FL_MAN_W'(0)};
    else if (e_adj <= 10'sd0) norm_res_c = {sign, (FL_W-1)'(0)};
    else                      norm_res_c = {sign, e_adj[FL_EXP_W-1:0], mant};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !spec_c) state_nxt = DIVIDE;
      DIVIDE:  if (last_c) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    quotient_nxt = quotient;
    done_nxt     = 1'b0;
    case (state)
      IDLE: if (start && spec_c) begin
        quotient_nxt = spec_res_c;
        done_nxt     = 1'b1;
      end
      NORM: begin
        quotient_nxt = norm_res_c;
        done_nxt     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      quotient <= quotient_nxt;
      done     <= done_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule
